pipe_hazard_ctrl: RTL and testbench

//  Pipeline scheduler for the 5-stage core around the forwarding regfile. Forwarding covers ALU results, not

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_div_seq.sv | 79 +++++++
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
//   STALL_W      width of the per-stage hold vector {wb,mem,ex,id,if,pc}
//   STALL_*      hold patterns driven onto the stall vector
//   hz_state_e   divide sequencer states
package pipe_hazard_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  // Hold pc/if/id; EX gets a bubble so the load reaches MEM before its consumer reads it.
  localparam logic [STALL_W-1:0] STALL_LUSE = 6'b000111;
  // Hold everything up to EX; MEM keeps draining and receives bubbles.
  localparam logic [STALL_W-1:0] STALL_DIV  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_DIV_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_div_seq.sv
// hz_div_seq: divide hand-off sequencer.
// Tracks the RUN/DIV_BUSY state, runs the watchdog counter and remembers a
// div_ready pulse that arrives while the pipe is frozen.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   freeze        whole pipe frozen this cycle (state/counter held)
//   launch        a divide sits in EX
//   div_ready     divider result pulse
//   busy          sequencer is in DIV_BUSY
//   start         divide launches this cycle (drives div_start)
//   release_now   DIV_BUSY ends this cycle (result or watchdog), EX may advance
//   div_timeout   sticky watchdog flag
module hz_div_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic freeze,
  input  logic launch,
  input  logic div_ready,
  output logic busy,
  output logic start,
  output logic release_now,
  output logic div_timeout
);

  localparam int CW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);

  hz_state_e     state;
  logic [CW-1:0] cnt;
  logic          pend;
  logic          ready_any;
  logic          wdog;

  assign busy        = (state == HZ_DIV_BUSY);
  assign ready_any   = div_ready | pend;
  assign wdog        = (cnt == CNT_LAST);
  assign start       = (state == HZ_RUN) & launch & ~freeze;
  // A ready seen during a freeze (pend) releases on the first unfrozen cycle.
  assign release_now = busy & ~freeze & (ready_any | wdog);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= HZ_RUN;
      cnt         <= '0;
      pend        <= 1'b0;
      div_timeout <= 1'b0;
    end else if (freeze) begin
      // Only a result for an outstanding divide is worth remembering.
      if (busy && div_ready) pend <= 1'b1;
    end else begin
      case (state)
        HZ_RUN: begin
          pend <= 1'b0;
          if (launch) begin
            state <= HZ_DIV_BUSY;
            cnt   <= '0;
          end
        end
        HZ_DIV_BUSY: begin
          if (ready_any) begin
            state <= HZ_RUN;
            pend  <= 1'b0;
          end else if (wdog) begin
            state       <= HZ_RUN;
            div_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: bubble/freeze scheduler for the 5-stage core.
// Covers the cases forwarding cannot: load-use on a load still in EX, and a
// multi-cycle divide. Also counts cycles with the IF stage held.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   id_valid, id_re1/2, id_raddr1/2  ID instruction and its register reads
//   ex_valid, ex_is_load, ex_is_div, ex_rf_we, ex_rf_waddr  EX instruction
//   div_ready                      divider result pulse
//   ext_stall_req                  bus not ready, freeze whole pipe
//   stall[5:0]                     hold per stage, bit0=pc .. bit5=wb
//   flush_ex                       load a bubble into EX
//   div_start                      1-cycle divider start pulse
//   div_timeout                    sticky divide watchdog flag
//   stall_cnt                      saturating count of cycles with stall[1]
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               id_valid,
  input  logic               id_re1,
  input  logic [4:0]         id_raddr1,
  input  logic               id_re2,
  input  logic [4:0]         id_raddr2,
  input  logic               ex_valid,
  input  logic               ex_is_load,
  input  logic               ex_is_div,
  input  logic               ex_rf_we,
  input  logic [4:0]         ex_rf_waddr,
  input  logic               div_ready,
  input  logic               ext_stall_req,
  output logic [STALL_W-1:0] stall,
  output logic               flush_ex,
  output logic               div_start,
  output logic               div_timeout,
  output logic [CNT_W-1:0]   stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic luse;
  logic div_busy;
  logic div_launch;
  logic div_release;

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign luse = id_valid & ex_valid & ex_is_load & ex_rf_we & (ex_rf_waddr != 5'd0) &
                ((id_re1 & (id_raddr1 == ex_rf_waddr)) |
                 (id_re2 & (id_raddr2 == ex_rf_waddr)));

  hz_div_seq #(
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) u_div_seq (
    .clk         (clk),
    .resetn      (resetn),
    .freeze      (ext_stall_req),
    .launch      (ex_valid & ex_is_div),
    .div_ready   (div_ready),
    .busy        (div_busy),
    .start       (div_launch),
    .release_now (div_release),
    .div_timeout (div_timeout)
  );

  // Priority: external freeze, then divide, then load-use (never during a divide).
  always_comb begin
    stall     = STALL_NONE;
    flush_ex  = 1'b0;
    div_start = 1'b0;
    if (resetn) begin
      if (ext_stall_req) begin
        stall = STALL_ALL;
      end else if (div_launch) begin
        stall     = STALL_DIV;
        div_start = 1'b1;
      end else if (div_busy) begin
        stall = div_release ? STALL_NONE : STALL_DIV;
      end else if (luse) begin
        stall    = STALL_LUSE;
        flush_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stall[1]) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share the stimulus:
// dut a (DIV_TIMEOUT=64, CNT_W=6) for divide/freeze/saturation sequences,
// dut b (DIV_TIMEOUT=8, CNT_W=32) for the watchdog sequence.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       id_valid, id_re1, id_re2;
  logic [4:0] id_raddr1, id_raddr2;
  logic       ex_valid, ex_is_load, ex_is_div, ex_rf_we;
  logic [4:0] ex_rf_waddr;
  logic       div_ready, ext_stall_req;

  logic [5:0]  a_stall, b_stall;
  logic        a_flush, b_flush, a_dstart, b_dstart, a_dto, b_dto;
  logic [5:0]  a_cnt;
  logic [31:0] b_cnt;

  pipe_hazard_ctrl #(.DIV_TIMEOUT(64), .CNT_W(6)) dut_a (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_re1(id_re1), .id_raddr1(id_raddr1),
    .id_re2(id_re2), .id_raddr2(id_raddr2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_div(ex_is_div),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .div_ready(div_ready), .ext_stall_req(ext_stall_req),
    .stall(a_stall), .flush_ex(a_flush), .div_start(a_dstart),
    .div_timeout(a_dto), .stall_cnt(a_cnt)
  );

  pipe_hazard_ctrl #(.DIV_TIMEOUT(8), .CNT_W(32)) dut_b (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_re1(id_re1), .id_raddr1(id_raddr1),
    .id_re2(id_re2), .id_raddr2(id_raddr2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_div(ex_is_div),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .div_ready(div_ready), .ext_stall_req(ext_stall_req),
    .stall(b_stall), .flush_ex(b_flush), .div_start(b_dstart),
    .div_timeout(b_dto), .stall_cnt(b_cnt)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_valid = 0; id_re1 = 0; id_raddr1 = 0; id_re2 = 0; id_raddr2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_is_div = 0; ex_rf_we = 0; ex_rf_waddr = 0;
    div_ready = 0; ext_stall_req = 0;
  endtask

  task automatic set_div();
    set_idle();
    ex_valid = 1; ex_is_div = 1; ex_rf_we = 1; ex_rf_waddr = 5'd9;
  endtask

  // lw r5 in EX, ID consumes r5 through port 1
  task automatic set_luse();
    set_idle();
    id_valid = 1; id_re1 = 1; id_raddr1 = 5'd5;
    ex_valid = 1; ex_is_load = 1; ex_rf_we = 1; ex_rf_waddr = 5'd5;
  endtask

  // Inputs change just after a rising edge; outputs are compared on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    resetn = 0;
    set_idle();
    next_cycle();
    resetn = 1;
  endtask

  typedef struct {
    logic       idv;
    logic       re1;
    logic [4:0] ra1;
    logic       re2;
    logic [4:0] ra2;
    logic       exv;
    logic       ld;
    logic       we;
    logic [4:0] wa;
    logic       ext;
    logic [5:0] st;
    logic       fl;
  } vec_t;

  vec_t tbl[13];
  int   exp_cnt;

  initial begin
    //            idv re1 ra1 re2 ra2 exv ld  we  wa  ext  stall   flush
    tbl[0]  = '{1'b0,1'b0,5'd0, 1'b0,5'd0,1'b0,1'b0,1'b0,5'd0, 1'b0,6'h00,1'b0};
    tbl[1]  = '{1'b1,1'b1,5'd5, 1'b1,5'd1,1'b1,1'b1,1'b1,5'd5, 1'b0,6'h07,1'b1};
    tbl[2]  = '{1'b1,1'b1,5'd5, 1'b1,5'd1,1'b0,1'b0,1'b0,5'd0, 1'b0,6'h00,1'b0};
    tbl[3]  = '{1'b1,1'b1,5'd3, 1'b1,5'd5,1'b1,1'b1,1'b1,5'd5, 1'b0,6'h07,1'b1};
    tbl[4]  = '{1'b1,1'b1,5'd0, 1'b1,5'd0,1'b1,1'b1,1'b1,5'd0, 1'b0,6'h00,1'b0};
    tbl[5]  = '{1'b1,1'b1,5'd1, 1'b0,5'd5,1'b1,1'b1,1'b1,5'd5, 1'b0,6'h00,1'b0};
    tbl[6]  = '{1'b1,1'b0,5'd5, 1'b1,5'd2,1'b1,1'b1,1'b1,5'd5, 1'b0,6'h00,1'b0};
    tbl[7]  = '{1'b1,1'b1,5'd5, 1'b0,5'd0,1'b1,1'b1,1'b0,5'd5, 1'b0,6'h00,1'b0};
    tbl[8]  = '{1'b1,1'b1,5'd5, 1'b0,5'd0,1'b1,1'b0,1'b1,5'd5, 1'b0,6'h00,1'b0};
    tbl[9]  = '{1'b0,1'b1,5'd5, 1'b0,5'd0,1'b1,1'b1,1'b1,5'd5, 1'b0,6'h00,1'b0};
    tbl[10] = '{1'b1,1'b1,5'd6, 1'b1,5'd7,1'b1,1'b1,1'b1,5'd5, 1'b0,6'h00,1'b0};
    tbl[11] = '{1'b1,1'b1,5'd5, 1'b0,5'd0,1'b1,1'b1,1'b1,5'd5, 1'b1,6'h3f,1'b0};
    tbl[12] = '{1'b1,1'b1,5'd31,1'b0,5'd0,1'b1,1'b1,1'b1,5'd31,1'b0,6'h07,1'b1};

    // Reset: outputs forced low even with a hazard and a freeze request present.
    resetn = 0;
    set_luse();
    ext_stall_req = 1;
    #2;
    chk("reset_stall_a", a_stall, 6'h00);
    chk("reset_flush_a", a_flush, 0);
    chk("reset_dstart_b", b_dstart, 0);
    chk("reset_cnt_a", a_cnt, 0);
    chk("reset_dto_b", b_dto, 0);
    do_reset();

    // Single-cycle hazard table, all in RUN.
    exp_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      set_idle();
      id_valid = tbl[i].idv; id_re1 = tbl[i].re1; id_raddr1 = tbl[i].ra1;
      id_re2 = tbl[i].re2; id_raddr2 = tbl[i].ra2;
      ex_valid = tbl[i].exv; ex_is_load = tbl[i].ld; ex_rf_we = tbl[i].we;
      ex_rf_waddr = tbl[i].wa; ext_stall_req = tbl[i].ext;
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), a_stall, tbl[i].st);
      chk($sformatf("tbl%0d_flush", i), a_flush, tbl[i].fl);
      chk($sformatf("tbl%0d_dstart", i), a_dstart, 0);
      if (tbl[i].st[1]) exp_cnt++;
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    chk("tbl_stall_cnt", a_cnt, exp_cnt);

    // Divide on dut a: launch + 32 busy stall cycles, result on the 34th cycle.
    do_reset();
    set_div();
    @(negedge clk);
    chk("div_launch_start", a_dstart, 1);
    chk("div_launch_stall", a_stall, 6'h0f);
    chk("div_launch_flush", a_flush, 0);
    for (int i = 1; i < 33; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("div_busy%0d_stall", i), a_stall, 6'h0f);
      chk($sformatf("div_busy%0d_start", i), a_dstart, 0);
    end
    next_cycle();
    div_ready = 1;
    @(negedge clk);
    chk("div_ready_stall", a_stall, 6'h00);
    chk("div_ready_start", a_dstart, 0);
    next_cycle();
    set_idle();
    div_ready = 1;           // stray result while in RUN
    @(negedge clk);
    chk("div_run_ready_stall", a_stall, 6'h00);
    next_cycle();
    set_luse();
    @(negedge clk);
    chk("div_after_luse", a_stall, 6'h07);
    chk("div_cnt", a_cnt, 33 + 1 - 1);
    chk("div_no_timeout", a_dto, 0);

    // Watchdog on dut b (DIV_TIMEOUT=8): 8 stall cycles then forced release.
    do_reset();
    set_div();
    @(negedge clk);
    chk("wd_launch_start", b_dstart, 1);
    for (int i = 1; i < 8; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("wd_busy%0d_stall", i), b_stall, 6'h0f);
    end
    next_cycle();
    @(negedge clk);
    chk("wd_release_stall", b_stall, 6'h00);
    chk("wd_flag_not_yet", b_dto, 0);
    next_cycle();
    set_idle();
    @(negedge clk);
    chk("wd_flag_set", b_dto, 1);
    chk("wd_run_stall", b_stall, 6'h00);
    repeat (3) next_cycle();
    set_luse();
    @(negedge clk);
    chk("wd_flag_sticky", b_dto, 1);
    chk("wd_state_run", b_stall, 6'h07);

    // Freeze during DIV_BUSY with a result arriving mid-freeze (dut a).
    do_reset();
    set_div();
    repeat (4) next_cycle();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      ext_stall_req = 1;
      div_ready = (i == 1);
      @(negedge clk);
      chk($sformatf("frz%0d_stall", i), a_stall, 6'h3f);
      chk($sformatf("frz%0d_start", i), a_dstart, 0);
    end
    next_cycle();
    ext_stall_req = 0;
    div_ready = 0;
    @(negedge clk);
    chk("frz_pend_release", a_stall, 6'h00);
    next_cycle();
    set_luse();
    @(negedge clk);
    chk("frz_state_run", a_stall, 6'h07);

    // Asynchronous reset in the middle of a divide.
    do_reset();
    set_div();
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_mid_busy", a_stall, 6'h0f);
    next_cycle();
    resetn = 0;
    #1;
    chk("rst_mid_stall", a_stall, 6'h00);
    chk("rst_mid_start", a_dstart, 0);
    next_cycle();
    set_idle();
    resetn = 1;
    @(negedge clk);
    chk("rst_after_stall", a_stall, 6'h00);
    chk("rst_after_start", a_dstart, 0);
    next_cycle();
    set_luse();
    @(negedge clk);
    chk("rst_after_run", a_stall, 6'h07);

    // Counter saturation: CNT_W=6 on dut a tops out at 63.
    do_reset();
    ext_stall_req = 1;
    repeat (62) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt62", a_cnt, 62);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt_hold", a_cnt, 63);
    chk("sat_cnt_b", b_cnt, 70);
    set_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
